// File: rtl/matrix_scan_reader.sv
// rtl/matrix_scan_reader.sv - Avalon-MM frame-buffer read master driving a HUB75 panel
// Double-buffered source select, binary-code-modulated bit-planes, 1/(ROWS/2) scan.
module matrix_scan_reader #(
  parameter int COLS       = 64,
  parameter int ROWS       = 32,
  parameter int PLANES     = 8,
  parameter int BASE_TICKS = 16,
  parameter int ADDR_W     = 11
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic                       enable,
  input  logic                       buf_sel,
  output logic                       active_buf,
  output logic                       frame_done,
  output logic [ADDR_W-1:0]          ram1_address,
  output logic                       ram1_clken,
  output logic                       ram1_chipselect,
  output logic                       ram1_write,
  output logic [31:0]                ram1_writedata,
  output logic [3:0]                 ram1_byteenable,
  input  logic [31:0]                ram1_readdata,
  output logic [ADDR_W-1:0]          ram2_address,
  output logic                       ram2_clken,
  output logic                       ram2_chipselect,
  output logic                       ram2_write,
  output logic [31:0]                ram2_writedata,
  output logic [3:0]                 ram2_byteenable,
  input  logic [31:0]                ram2_readdata,
  output logic                       mat_r1,
  output logic                       mat_g1,
  output logic                       mat_b1,
  output logic                       mat_r2,
  output logic                       mat_g2,
  output logic                       mat_b2,
  output logic [$clog2(ROWS/2)-1:0]  mat_row,
  output logic                       mat_clk,
  output logic                       mat_lat,
  output logic                       mat_oe_n
);
  localparam int SCAN  = ROWS / 2;
  localparam int ROW_W = $clog2(SCAN);
  localparam int COL_W = $clog2(COLS);
  localparam int TW    = $clog2(BASE_TICKS) + PLANES;

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, DISPLAY} state_t;
  state_t state, next_state;

  logic [COL_W-1:0]  col;
  logic [1:0]        phase;
  logic [ROW_W-1:0]  row;
  logic [ROW_W-1:0]  row_q;
  logic [2:0]        plane;
  logic [TW-1:0]     tick;
  logic [23:0]       upper;
  logic [5:0]        pix_q;
  logic [5:0]        pix_now;
  logic [5:0]        pix;
  logic [23:0]       rd;
  logic [2:0]        pb;
  logic [TW-1:0]     disp_len;
  logic [ADDR_W-1:0] addr_up;
  logic [ADDR_W-1:0] addr_lo;
  logic [ADDR_W-1:0] addr;
  logic              col_last, tick_last, plane_last, row_last;
  logic              fetching, shift_data;
  logic              unused_bits;

  assign unused_bits = ^{ram1_readdata[31:24], ram2_readdata[31:24]};

  assign col_last   = (col == COL_W'(COLS - 1));
  assign plane_last = (plane == 3'(PLANES - 1));
  assign row_last   = (row == ROW_W'(SCAN - 1));
  assign disp_len   = TW'(BASE_TICKS) << plane;
  assign tick_last  = (tick == disp_len - TW'(1));
  assign fetching   = (state == FETCH);
  assign shift_data = fetching && (phase == 2'd2);

  // Upper word is read in C0, lower word in C1; holding the lower address afterwards is harmless.
  assign addr_up = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  assign addr_lo = addr_up + ADDR_W'(SCAN * COLS);
  assign addr    = (phase == 2'd0) ? addr_up : addr_lo;

  assign ram1_chipselect = fetching && !active_buf;
  assign ram2_chipselect = fetching && active_buf;
  assign ram1_clken      = ram1_chipselect;
  assign ram2_clken      = ram2_chipselect;
  assign ram1_address    = ram1_chipselect ? addr : '0;
  assign ram2_address    = ram2_chipselect ? addr : '0;
  assign ram1_write      = 1'b0;
  assign ram2_write      = 1'b0;
  assign ram1_writedata  = '0;
  assign ram2_writedata  = '0;
  assign ram1_byteenable = 4'hF;
  assign ram2_byteenable = 4'hF;

  assign rd      = active_buf ? ram2_readdata[23:0] : ram1_readdata[23:0];
  assign pb      = 3'(8 - PLANES) + plane;
  assign pix_now = {upper[16 + int'(pb)], upper[8 + int'(pb)], upper[int'(pb)],
                    rd[16 + int'(pb)], rd[8 + int'(pb)], rd[int'(pb)]};
  // The lower word only exists on readdata during C2, so C2 shows it directly and C3 holds it.
  assign pix     = shift_data ? pix_now : pix_q;
  assign {mat_r1, mat_g1, mat_b1, mat_r2, mat_g2, mat_b2} = pix;

  assign mat_clk  = fetching && (phase == 2'd3);
  assign mat_lat  = (state == LATCH);
  assign mat_oe_n = (state != DISPLAY);
  assign mat_row  = row_q;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state <= IDLE;
    else             state <= next_state;
  end

  always_comb begin
    next_state = state;
    frame_done = 1'b0;
    case (state)
      IDLE:    if (enable) next_state = FETCH;
      FETCH:   if (phase == 2'd3 && col_last) next_state = LATCH;
      LATCH:   next_state = DISPLAY;
      DISPLAY: begin
        if (tick_last) begin
          if (plane_last && row_last) begin
            next_state = IDLE;
            frame_done = 1'b1;
          end else begin
            next_state = FETCH;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      active_buf <= 1'b0;
      col        <= '0;
      phase      <= '0;
      row        <= '0;
      row_q      <= '0;
      plane      <= '0;
      tick       <= '0;
      upper      <= '0;
      pix_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) active_buf <= buf_sel;
          col   <= '0;
          phase <= '0;
          tick  <= '0;
        end
        FETCH: begin
          phase <= phase + 2'd1;
          if (phase == 2'd1) upper <= rd;
          if (phase == 2'd2) pix_q <= pix_now;
          if (phase == 2'd3) col <= col_last ? '0 : col + COL_W'(1);
        end
        LATCH: begin
          row_q <= row;
          tick  <= '0;
        end
        DISPLAY: begin
          tick <= tick + TW'(1);
          if (tick_last) begin
            tick  <= '0;
            col   <= '0;
            phase <= '0;
            if (plane_last) begin
              plane <= '0;
              row   <= row_last ? '0 : row + ROW_W'(1);
            end else begin
              plane <= plane + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_scan_reader.sv
// tb/tb_matrix_scan_reader.sv - self-checking bench for matrix_scan_reader
// Small panel geometry keeps each frame short; pixel vectors are compared against a captured frame.
module tb_matrix_scan_reader;
  localparam int COLS  = 8;
  localparam int ROWS  = 32;
  localparam int PL    = 8;
  localparam int BT    = 1;
  localparam int AW    = 11;
  localparam int FRAME = 16 * (PL * (4 * COLS + 1) + BT * ((1 << PL) - 1)) + 1;

  logic clk_clk = 1'b0;
  logic reset_reset, enable, buf_sel;
  logic active_buf, frame_done;
  logic [AW-1:0] ram1_address, ram2_address;
  logic ram1_clken, ram1_chipselect, ram1_write, ram2_clken, ram2_chipselect, ram2_write;
  logic [31:0] ram1_writedata, ram2_writedata, ram1_readdata, ram2_readdata;
  logic [3:0] ram1_byteenable, ram2_byteenable;
  logic mat_r1, mat_g1, mat_b1, mat_r2, mat_g2, mat_b2, mat_clk, mat_lat, mat_oe_n;
  logic [3:0] mat_row;

  matrix_scan_reader #(.COLS(COLS), .ROWS(ROWS), .PLANES(PL), .BASE_TICKS(BT), .ADDR_W(AW)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .enable(enable), .buf_sel(buf_sel),
    .active_buf(active_buf), .frame_done(frame_done),
    .ram1_address(ram1_address), .ram1_clken(ram1_clken), .ram1_chipselect(ram1_chipselect),
    .ram1_write(ram1_write), .ram1_writedata(ram1_writedata), .ram1_byteenable(ram1_byteenable),
    .ram1_readdata(ram1_readdata),
    .ram2_address(ram2_address), .ram2_clken(ram2_clken), .ram2_chipselect(ram2_chipselect),
    .ram2_write(ram2_write), .ram2_writedata(ram2_writedata), .ram2_byteenable(ram2_byteenable),
    .ram2_readdata(ram2_readdata),
    .mat_r1(mat_r1), .mat_g1(mat_g1), .mat_b1(mat_b1), .mat_r2(mat_r2), .mat_g2(mat_g2), .mat_b2(mat_b2),
    .mat_row(mat_row), .mat_clk(mat_clk), .mat_lat(mat_lat), .mat_oe_n(mat_oe_n)
  );

  always #5 clk_clk = ~clk_clk;

  logic [31:0] mem1 [0:(1<<AW)-1];
  logic [31:0] mem2 [0:(1<<AW)-1];
  initial begin
    ram1_readdata = '0;
    ram2_readdata = '0;
  end
  always @(posedge clk_clk) begin
    if (ram1_clken) ram1_readdata <= mem1[ram1_address];
    if (ram2_clken) ram2_readdata <= mem2[ram2_address];
  end

  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Panel-side monitor: captures every shifted pixel by (scan row, plane, column).
  logic [5:0] cap [0:15][0:PL-1][0:COLS-1];
  int cyc = 0, pass = 0, idx = 0, cur_plane = 0, run = 0;
  int fd_cyc = 0, period = 0, have_fd = 0;
  int cs1_cnt = 0, cs2_cnt = 0, write_bad = 0, lat_oe_bad = 0, shift_bad = 0;
  int run_len [0:PL-1];
  bit seen_a = 0, seen_b = 0;
  logic prev_mclk = 1'b0, prev_oe = 1'b1;

  always @(posedge clk_clk) cyc++;

  always @(negedge clk_clk) begin
    if (reset_reset) begin
      pass = 0; idx = 0; have_fd = 0; run = 0; prev_mclk = 1'b0; prev_oe = 1'b1;
    end else begin
      if (ram1_write || ram2_write) write_bad++;
      if (mat_lat && !mat_oe_n) lat_oe_bad++;
      if (ram1_chipselect) cs1_cnt++;
      if (ram2_chipselect) cs2_cnt++;
      if (ram2_chipselect && ram2_address == 11'd29) seen_a = 1;
      if (ram2_chipselect && ram2_address == 11'd157) seen_b = 1;
      if (mat_clk && !prev_mclk) begin
        if (idx < COLS && pass < 16 * PL)
          cap[pass / PL][pass % PL][idx] = {mat_r1, mat_g1, mat_b1, mat_r2, mat_g2, mat_b2};
        idx++;
      end
      if (mat_lat) begin
        if (idx != COLS) shift_bad++;
        idx = 0;
        cur_plane = pass % PL;
        pass++;
      end
      if (!mat_oe_n) run++;
      else if (!prev_oe) begin
        run_len[cur_plane] = run;
        run = 0;
      end
      if (frame_done) begin
        if (have_fd != 0) period = cyc - fd_cyc;
        fd_cyc = cyc;
        have_fd = 1;
        pass = 0;
      end
      prev_mclk = mat_clk;
      prev_oe = mat_oe_n;
    end
  end

  task automatic wait_frame(output bit ok);
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk_clk); #1;
      if (frame_done) begin
        ok = 1;
        break;
      end
    end
  endtask

  typedef struct {
    int row;
    int col;
    int plane;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs [15];

  initial begin
    bit ok;
    int bad;
    vecs[0]  = '{3, 5, 7, 6'b001000};
    vecs[1]  = '{3, 5, 6, 6'b000000};
    vecs[2]  = '{3, 5, 0, 6'b000000};
    vecs[3]  = '{3, 2, 0, 6'b000100};
    vecs[4]  = '{3, 2, 1, 6'b000000};
    vecs[5]  = '{0, 0, 0, 6'b111000};
    vecs[6]  = '{0, 0, 7, 6'b111000};
    vecs[7]  = '{15, 7, 0, 6'b000010};
    vecs[8]  = '{15, 7, 1, 6'b000100};
    vecs[9]  = '{15, 7, 3, 6'b000100};
    vecs[10] = '{15, 7, 7, 6'b000100};
    vecs[11] = '{8, 4, 4, 6'b111000};
    vecs[12] = '{8, 4, 2, 6'b011000};
    vecs[13] = '{8, 4, 1, 6'b101000};
    vecs[14] = '{8, 3, 4, 6'b000000};
    for (int a = 0; a < (1 << AW); a++) begin
      mem1[a] = 32'h00FF0000;
      mem2[a] = 32'h0;
    end
    mem2[3*COLS+5]  = 32'h00000080;
    mem2[19*COLS+2] = 32'h00010000;
    mem2[0]         = 32'h00FFFFFF;
    mem2[31*COLS+7] = 32'h00AA5500;
    mem2[15*COLS+7] = 32'hFF000000;
    mem2[8*COLS+4]  = 32'h00123456;
    for (int p = 0; p < PL; p++) run_len[p] = 0;

    reset_reset = 1'b1; enable = 1'b0; buf_sel = 1'b0;
    repeat (2) @(posedge clk_clk); #1;
    chk("rst_oe_n", mat_oe_n, 1);
    chk("rst_mat", {mat_r1, mat_g1, mat_b1, mat_r2, mat_g2, mat_b2, mat_clk, mat_lat, mat_row}, 0);
    chk("rst_ctl", {active_buf, frame_done}, 0);
    chk("rst_ram1", {ram1_chipselect, ram1_clken, ram1_write, ram1_address}, 0);
    chk("rst_ram2", {ram2_chipselect, ram2_clken, ram2_write, ram2_address}, 0);
    chk("rst_be", {ram1_byteenable, ram2_byteenable}, 8'hFF);
    chk("rst_wd", {ram1_writedata, ram2_writedata}, 0);

    @(negedge clk_clk); reset_reset = 1'b0;
    bad = 0;
    repeat (5) begin
      @(posedge clk_clk); #1;
      if (ram1_chipselect || ram2_chipselect || !mat_oe_n) bad++;
    end
    chk("idle_while_disabled", bad, 0);

    // Frame 1 from ram1 (all red); buf_sel flips mid-frame.
    @(negedge clk_clk); enable = 1'b1;
    @(posedge clk_clk); #1;
    chk("first_fetch_cs1", {ram1_chipselect, ram2_chipselect, ram1_address}, {2'b10, 11'd0});
    cs1_cnt = 0; cs2_cnt = 0;
    repeat (1000) @(posedge clk_clk); #1;
    buf_sel = 1'b1;
    repeat (3) @(posedge clk_clk); #1;
    chk("active_buf_mid_frame", active_buf, 0);
    wait_frame(ok);
    chk("frame1_done_seen", ok, 1);
    chk("active_buf_at_done", active_buf, 0);
    bad = 0;
    for (int r = 0; r < 16; r++)
      for (int p = 0; p < PL; p++)
        for (int c = 0; c < COLS; c++)
          if (cap[r][p][c] !== 6'b100100) bad++;
    chk("frame1_red_pixels_bad", bad, 0);
    chk("frame1_cs2_cycles", cs2_cnt, 0);
    cs1_cnt = 0; cs2_cnt = 0; seen_a = 0; seen_b = 0;
    @(posedge clk_clk); #1;
    chk("idle_after_done", {ram1_chipselect, ram2_chipselect, mat_oe_n, active_buf}, 4'b0010);
    @(posedge clk_clk); #1;
    chk("frame2_start", {active_buf, ram1_chipselect, ram2_chipselect, ram2_address}, {3'b101, 11'd0});

    // Frame 2 from ram2 carries the directed pixel vectors.
    wait_frame(ok);
    chk("frame2_done_seen", ok, 1);
    for (int i = 0; i < 15; i++)
      chk($sformatf("pix_r%0d_c%0d_p%0d", vecs[i].row, vecs[i].col, vecs[i].plane),
          cap[vecs[i].row][vecs[i].plane][vecs[i].col], vecs[i].exp);
    chk("addr_197_equiv_seen", seen_a, 1);
    chk("addr_1221_equiv_seen", seen_b, 1);
    chk("frame2_cs1_cycles", cs1_cnt, 0);
    @(negedge clk_clk); #1;
    chk("frame_period", period, FRAME);
    chk("plane7_oe_window", run_len[PL-1], BT << (PL - 1));
    chk("plane0_oe_window", run_len[0], BT);

    // Reset while the panel is lit in frame 3.
    bad = 0;
    while (mat_oe_n && bad < 2000) begin
      @(posedge clk_clk); #1;
      bad++;
    end
    chk("display_reached", mat_oe_n, 0);
    #2 reset_reset = 1'b1;
    #1;
    chk("rst_mid_oe_n", mat_oe_n, 1);
    chk("rst_mid_lat_cs", {mat_lat, ram1_chipselect, ram2_chipselect}, 0);
    @(negedge clk_clk); @(negedge clk_clk);
    reset_reset = 1'b0;
    #1;
    chk("rst_release_idle", {ram1_chipselect, ram2_chipselect, mat_oe_n}, 3'b001);
    @(posedge clk_clk); #1;
    chk("rst_release_fetch", {active_buf, ram1_chipselect, ram2_chipselect, ram2_address}, {3'b101, 11'd0});

    // Dropping enable mid-frame still lets the frame finish, then the reader parks in IDLE.
    repeat (10) @(posedge clk_clk); #1;
    enable = 1'b0;
    wait_frame(ok);
    chk("frame3_completes", ok, 1);
    bad = 0;
    repeat (30) begin
      @(posedge clk_clk); #1;
      if (ram1_chipselect || ram2_chipselect || !mat_oe_n || mat_clk) bad++;
    end
    chk("parked_after_disable", bad, 0);

    chk("ram_write_seen", write_bad, 0);
    chk("lat_with_oe_low", lat_oe_bad, 0);
    chk("shifts_per_latch_bad", shift_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
